// File: rtl/or_result_checker.sv
// Receive-side checker for the bitwise OR datapath: buffers {a, b, out} triples,
// compares each against a|b, and keeps vector/error counts plus an MISR of results.
module or_result_checker #(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 4,
    parameter int               CNT_W       = 8,
    parameter logic [WIDTH-1:0] POLY        = 8'h1D,
    parameter int               STOP_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_out,
    input  logic             check_en,
    output logic             mismatch,
    output logic [WIDTH-1:0] exp_val,
    output logic [WIDTH-1:0] got_val,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH-1:0] signature,
    output logic             halted,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, CHECK, HALT} state_t;

    logic [WIDTH-1:0] a_mem [DEPTH];
    logic [WIDTH-1:0] b_mem [DEPTH];
    logic [WIDTH-1:0] o_mem [DEPTH];

    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      count_reg, count_next;
    state_t           state_reg;
    logic             mismatch_reg;
    logic [WIDTH-1:0] exp_reg, got_reg, sig_reg, sig_next;
    logic [CNT_W-1:0] vec_reg, err_reg;

    logic             push, pop, bad;
    logic [WIDTH-1:0] pop_a, pop_b, pop_out, pop_exp;

    assign in_ready = (count_reg != DEPTH[AW:0]);
    assign empty    = (count_reg == '0);
    assign push     = in_valid && in_ready;
    assign pop      = !empty && check_en && (state_reg != HALT);

    assign pop_a    = a_mem[rd_ptr_reg];
    assign pop_b    = b_mem[rd_ptr_reg];
    assign pop_out  = o_mem[rd_ptr_reg];
    assign pop_exp  = pop_a | pop_b;
    assign bad      = (pop_exp != pop_out);

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // MISR: shift left, fold the dropped MSB back through POLY, mix in the observed value.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_misr
            if (gi == 0) begin : g_lsb
                assign sig_next[gi] = (sig_reg[WIDTH-1] & POLY[gi]) ^ pop_out[gi];
            end else begin : g_bit
                assign sig_next[gi] = sig_reg[gi-1] ^ (sig_reg[WIDTH-1] & POLY[gi]) ^ pop_out[gi];
            end
        end
    endgenerate

    // Storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            a_mem[wr_ptr_reg] <= in_a;
            b_mem[wr_ptr_reg] <= in_b;
            o_mem[wr_ptr_reg] <= in_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            state_reg    <= IDLE;
            mismatch_reg <= 1'b0;
            exp_reg      <= '0;
            got_reg      <= '0;
            sig_reg      <= '0;
            vec_reg      <= '0;
            err_reg      <= '0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                exp_reg      <= pop_exp;
                got_reg      <= pop_out;
                vec_reg      <= vec_reg + 1'b1;
                sig_reg      <= sig_next;
                mismatch_reg <= bad;
                if (bad && (err_reg != '1)) begin
                    err_reg <= err_reg + 1'b1;
                end
            end else begin
                mismatch_reg <= 1'b0;
            end

            case (state_reg)
                HALT: state_reg <= HALT;
                default: begin
                    if (pop && bad && (STOP_ON_ERR != 0)) begin
                        state_reg <= HALT;
                    end else if (count_next != '0) begin
                        state_reg <= CHECK;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

    assign mismatch  = mismatch_reg;
    assign exp_val   = exp_reg;
    assign got_val   = got_reg;
    assign vec_count = vec_reg;
    assign err_count = err_reg;
    assign signature = sig_reg;
    assign halted    = (state_reg == HALT);

endmodule
